// File: rtl/uart_alu_pkg.sv
// ---------------------------------------------------------------------------
// uart_alu_pkg : shared state encoding and elaboration helpers for the bridge
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_alu_pkg;

   localparam logic [2:0] ST_RX_A     = 3'd0;
   localparam logic [2:0] ST_RX_B     = 3'd1;
   localparam logic [2:0] ST_RX_OP    = 3'd2;
   localparam logic [2:0] ST_CAPTURE  = 3'd3;
   localparam logic [2:0] ST_TX_START = 3'd4;
   localparam logic [2:0] ST_TX_WAIT  = 3'd5;
   localparam logic [2:0] ST_CLEAR    = 3'd6;

   typedef enum logic [2:0] {
      RX_A     = ST_RX_A,
      RX_B     = ST_RX_B,
      RX_OP    = ST_RX_OP,
      CAPTURE  = ST_CAPTURE,
      TX_START = ST_TX_START,
      TX_WAIT  = ST_TX_WAIT,
      CLEAR    = ST_CLEAR
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int byte_size, input int data_size,
                                    input int opcode_size, input int timeout_cycles);
      return (byte_size > 0) && (data_size >= byte_size) &&
             ((data_size % byte_size) == 0) && (opcode_size > 0) &&
             (opcode_size <= byte_size) && (timeout_cycles >= 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_alu_bridge_rise_edge_pulse.sv
// ---------------------------------------------------------------------------
// rise_edge_pulse : one-cycle pulse on each rising edge of a level input
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rise_edge_pulse (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic pulse_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign pulse_o = level_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/uart_alu_bridge.sv
// ---------------------------------------------------------------------------
// uart_alu_bridge : assembles A/B/opcode from UART bytes, returns ALU result LSB first
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_alu_bridge
   import uart_alu_pkg::*;
#(
   parameter int BYTE_SIZE      = 8,
   parameter int DATA_SIZE      = 16,
   parameter int OPCODE_SIZE    = 6,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_rx_done,
   input  logic [BYTE_SIZE-1:0]   i_rx_data,
   input  logic                   i_tx_done,
   input  logic [DATA_SIZE-1:0]   i_alu_result,
   output logic                   o_tx_start,
   output logic [BYTE_SIZE-1:0]   o_tx_data,
   output logic [DATA_SIZE-1:0]   o_data_A,
   output logic [DATA_SIZE-1:0]   o_data_B,
   output logic [OPCODE_SIZE-1:0] o_data_OPCODE,
   output logic                   o_busy,
   output logic                   o_timeout_err
);

   localparam int               NBYTES   = DATA_SIZE / BYTE_SIZE;
   localparam int               IDX_W    = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
   localparam int               TMO_W    = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1
                                           : clog2(TIMEOUT_CYCLES + 1);

   generate
      if (!params_ok(BYTE_SIZE, DATA_SIZE, OPCODE_SIZE, TIMEOUT_CYCLES)) begin : g_param_check
         $error("uart_alu_bridge: illegal BYTE_SIZE/DATA_SIZE/OPCODE_SIZE/TIMEOUT_CYCLES");
      end
   endgenerate

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_SIZE-1:0]   a_q, a_d;
   logic [DATA_SIZE-1:0]   b_q, b_d;
   logic [OPCODE_SIZE-1:0] op_q, op_d;
   logic [DATA_SIZE-1:0]   res_q, res_d;
   logic [BYTE_SIZE-1:0]   txd_q, txd_d;
   logic                   txs_q, txs_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;

   logic w_rx_evt;
   logic w_tx_evt;
   logic w_tmo_active;
   logic w_timeout;

   rise_edge_pulse u_rx_edge (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .level_i (i_rx_done),
      .pulse_o (w_rx_evt)
   );

   rise_edge_pulse u_tx_edge (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .level_i (i_tx_done),
      .pulse_o (w_tx_evt)
   );

   // Inter-byte timer only runs once a frame has actually started.
   assign w_tmo_active = ((state_q == RX_A) && (idx_q != '0)) ||
                         (state_q == RX_B) || (state_q == RX_OP);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
         logic [TMO_W-1:0] tmo_cnt_q;

         always_ff @(posedge i_clk) begin
            if (i_reset || !w_tmo_active || w_timeout || w_rx_evt) begin
               tmo_cnt_q <= '0;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
         end

         assign w_timeout = w_tmo_active && (tmo_cnt_q == TMO_LIMIT);
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= RX_A;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         txd_q   <= '0;
         txs_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         txd_q   <= txd_d;
         txs_q   <= txs_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      txd_d   = txd_q;
      err_d   = w_timeout;

      case (state_q)
         RX_A: begin
            if (w_timeout) begin
               a_d     = '0;
               b_d     = '0;
               op_d    = '0;
               idx_d   = '0;
               state_d = RX_A;
            end else if (w_rx_evt) begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (idx_q == IDX_W'(i)) a_d[i*BYTE_SIZE +: BYTE_SIZE] = i_rx_data;
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = RX_B;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         RX_B: begin
            if (w_timeout) begin
               a_d     = '0;
               b_d     = '0;
               op_d    = '0;
               idx_d   = '0;
               state_d = RX_A;
            end else if (w_rx_evt) begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (idx_q == IDX_W'(i)) b_d[i*BYTE_SIZE +: BYTE_SIZE] = i_rx_data;
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = RX_OP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         RX_OP: begin
            if (w_timeout) begin
               a_d     = '0;
               b_d     = '0;
               op_d    = '0;
               idx_d   = '0;
               state_d = RX_A;
            end else if (w_rx_evt) begin
               op_d    = i_rx_data[OPCODE_SIZE-1:0];
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Opcode has been stable on the ALU for a full cycle by now.
            res_d   = i_alu_result;
            idx_d   = '0;
            state_d = TX_START;
         end
         TX_START: begin
            state_d = TX_WAIT;
         end
         TX_WAIT: begin
            if (w_tx_evt) begin
               if (idx_q == LAST_IDX) begin
                  state_d = CLEAR;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = TX_START;
               end
            end
         end
         CLEAR: begin
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            idx_d   = '0;
            state_d = RX_A;
         end
         default: begin
            idx_d   = '0;
            state_d = RX_A;
         end
      endcase

      // Outputs are derived from the next state so they line up with it.
      txs_d = (state_d == TX_START);
      if (txs_d) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (idx_d == IDX_W'(i)) txd_d = res_d[i*BYTE_SIZE +: BYTE_SIZE];
         end
      end
      busy_d = !((state_d == RX_A) && (idx_d == '0));
   end

   assign o_tx_start    = txs_q;
   assign o_tx_data     = txd_q;
   assign o_data_A      = a_q;
   assign o_data_B      = b_q;
   assign o_data_OPCODE = op_q;
   assign o_busy        = busy_q;
   assign o_timeout_err = err_q;

endmodule

`default_nettype wire

// File: doc/uart_alu_bridge.md
Name: uart_alu_bridge

Overview:
Parametrised successor of the UART-to-ALU interface. Assembles multi-byte operands A and B plus an opcode byte from the UART receiver and presents them to the combinational ALU. Captures the ALU result and serialises it back through the UART transmitter one byte at a time, least-significant byte (LSB) first. Adds an inter-byte receive timeout and edge-qualified handshakes. Sits between uart_rx/uart_tx and the ALU in the top level.

Parameters:
BYTE_SIZE, 8, UART payload width in bits.
DATA_SIZE, 16, operand and result width; must be an integer multiple of BYTE_SIZE, ≥ BYTE_SIZE.
OPCODE_SIZE, 6, opcode width; ≤ BYTE_SIZE; taken from the low bits of the opcode byte.
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
i_clk  in  1  system clock.
i_reset  in  1  synchronous, active-high reset.
i_rx_done  in  1  receiver byte-valid level; a byte is accepted on its rising edge only.
i_rx_data  in  BYTE_SIZE  received byte.
i_tx_done  in  1  transmitter byte-complete; completion is recognised on its rising edge only.
i_alu_result  in  DATA_SIZE  ALU output.
o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
o_tx_data  out  BYTE_SIZE  byte to transmit.
o_data_A  out  DATA_SIZE  operand A to the ALU.
o_data_B  out  DATA_SIZE  operand B to the ALU.
o_data_OPCODE  out  OPCODE_SIZE  opcode to the ALU.
o_busy  out  1  high whenever a frame is in progress.
o_timeout_err  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Single clock domain. All state changes on the i_clk rising edge. No combinational loops; all outputs are registered.
- Reset: on any edge with i_reset=1, all outputs and internal registers go to 0, and the state machine goes to RX_A with byte index 0. Reset aborts any operation in progress, including mid-transmit.
- NBYTES = DATA_SIZE/BYTE_SIZE. The byte index counter is clog2(NBYTES) bits wide, minimum 1.
- Edge detection: prev_rx and prev_tx are registered each cycle. rx_evt = i_rx_done & ~prev_rx; tx_evt = i_tx_done & ~prev_tx. A level held high counts once.
- States:
  - RX_A: on rx_evt, A[idx*BYTE_SIZE +: BYTE_SIZE] <= i_rx_data. At idx = NBYTES-1, go to RX_B with idx=0; otherwise idx++.
  - RX_B: same as RX_A for B; at the last byte go to RX_OP.
  - RX_OP: on rx_evt, o_data_OPCODE <= i_rx_data[OPCODE_SIZE-1:0]; go to CAPTURE.
  - CAPTURE: exactly one cycle. The result register <= i_alu_result, sampled one full cycle after the opcode is stable. idx=0. Go to TX_START.
  - TX_START: exactly one cycle. o_tx_start=1 and o_tx_data = result[idx*BYTE_SIZE +: BYTE_SIZE]. Go to TX_WAIT.
  - TX_WAIT: hold o_tx_data. On tx_evt: if idx = NBYTES-1, go to CLEAR; otherwise idx++ and go to TX_START.
  - CLEAR: one cycle. A, B, opcode, result and idx <= 0. Go to RX_A.
- Latency: opcode accepted at edge k; CAPTURE during cycle k+1; o_tx_start high during cycle k+2. Between tx_evt and the next o_tx_start there is exactly 1 cycle.
- o_busy = 1 in every state except RX_A with idx=0.
- Timeout:
  - The counter is active only in RX_A with idx>0, in RX_B, and in RX_OP.
  - It resets to 0 on every rx_evt and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: pulse o_timeout_err for 1 cycle, clear A/B/opcode/idx, go to RX_A. A byte arriving in that same cycle is dropped.
  - The counter is held at 0 in all other states and when TIMEOUT_CYCLES=0.
- rx_evt during CAPTURE, TX_START, TX_WAIT or CLEAR is ignored (byte dropped). tx_evt outside TX_WAIT is ignored.
- Simultaneous rx_evt and tx_evt: each is handled only by the state that owns it.
- o_data_A/B update byte-wise as bytes arrive; the ALU sees partial operands, which is harmless because the result is sampled only in CAPTURE.

Decomposition:
- Package uart_alu_pkg:
  - state encoding localparams (RX_A=0, RX_B=1, RX_OP=2, CAPTURE=3, TX_START=4, TX_WAIT=5, CLEAR=6);
  - a clog2 function;
  - an elaboration-time check on the parameter constraints.
- Sub-module rise_edge_pulse (registered previous value, one-cycle pulse output), instantiated twice, for rx and tx.

Test Plan:
- DATA_SIZE=16, ALU model = add. Send 0x34,0x12,0x05,0x00,0x20 → o_data_A=0x1234, o_data_B=0x0005. Two o_tx_start pulses with o_tx_data 0x39 then 0x12. o_busy drops after CLEAR; all operands read 0.
- Hold i_rx_done high for 10 cycles with data 0xAA → exactly one byte accepted (A[7:0]=0xAA, idx=1).
- TIMEOUT_CYCLES=50. Send 0x11 and then wait 50 cycles → o_timeout_err pulses once and A returns to 0. A following full frame computes correctly.
- Assert i_reset during TX_WAIT after the first result byte → next cycle all outputs are 0, and no further o_tx_start occurs until a new full frame is received.
- DATA_SIZE=8, BYTE_SIZE=8. Frame 0x07,0x03,0x22 with ALU = sub → single o_tx_start with o_tx_data=0x04. o_tx_start rises 2 cycles after the opcode rx edge.
- Pulse i_rx_done (0x99) during TX_WAIT → byte ignored; A stays 0 after CLEAR, and the result bytes are unchanged.
